timer_arbiter: RTL

//  Shares one TIMER instance (enbl/value/done) among N_REQ requesters.
//  - Grants the timer round-robin, loads the winner's delay value and runs the timer.
//  - Returns a one-cycle ack to the winner when the delay expires.
//  - Sits between control FSMs needing ms/us waits and a single TIMER, so there is no TIMER per client.

---
 rtl/timer_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one TIMER among N_REQ requesters.
// Grants, loads the winner's delay, runs the timer, acks on expiry.
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int VAL_W = 32,
    parameter int GID_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*VAL_W-1:0] req_value,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [GID_W-1:0]       grant_id,
    output logic                   tmr_enbl,
    output logic [31:0]            tmr_value,
    input  logic                   tmr_done
);

    if (VAL_W > 32) begin : g_bad_val_w
        $error("timer_arbiter: VAL_W above 32 is not supported");
    end
    if (GID_W != $clog2(N_REQ)) begin : g_bad_gid_w
        $error("timer_arbiter: GID_W must equal clog2(N_REQ)");
    end
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("timer_arbiter: N_REQ must be within 2..16");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_t;

    localparam logic [GID_W:0]   N_L  = (GID_W+1)'(N_REQ);
    localparam logic [GID_W-1:0] LAST = GID_W'(N_REQ - 1);

    state_t             state;
    state_t             state_d;
    logic [GID_W-1:0]   rr_ptr;
    logic [GID_W-1:0]   rr_d;
    logic [GID_W-1:0]   grant_d;
    logic [GID_W-1:0]   pos;
    logic [GID_W-1:0]   win;
    logic [GID_W:0]     win_sum;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   ack_d;
    logic [VAL_W-1:0]   win_val;
    logic [31:0]        value_d;
    logic               enbl_d;
    logic               busy_d;

    // Rotate req so rr_ptr sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        rot = N_REQ'({req, req} >> rr_ptr);
        pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = GID_W'(i);
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, pos};
        if (win_sum >= N_L) win_sum = win_sum - N_L;
        win = win_sum[GID_W-1:0];
        win_val = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == GID_W'(i)) win_val = req_value[i*VAL_W +: VAL_W];
        end
    end

    // Next-state and next-output decode; done beats a same-cycle cancel.
    always_comb begin
        state_d = state;
        ack_d   = '0;
        enbl_d  = tmr_enbl;
        grant_d = grant_id;
        value_d = tmr_value;
        rr_d    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_d = RUN;
                    enbl_d  = 1'b1;
                    grant_d = win;
                    value_d = 32'(win_val);
                    rr_d    = (win == LAST) ? '0 : win + 1'b1;
                end
            end
            RUN: begin
                if (tmr_done) begin
                    ack_d[grant_id] = 1'b1;
                    enbl_d          = 1'b0;
                    state_d         = GAP;
                end else if (!req[grant_id]) begin
                    enbl_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops tmr_enbl at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            tmr_enbl  <= 1'b0;
            tmr_value <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_d;
            ack       <= ack_d;
            busy      <= busy_d;
            grant_id  <= grant_d;
            tmr_enbl  <= enbl_d;
            tmr_value <= value_d;
        end
    end

endmodule
